// File: rtl/seq_multiplier_pkg.sv
// Shared constants and state encodings for the sequential shift-add multiplier
// and the controller that sequences it.
package seq_multiplier_pkg;

    localparam int unsigned DEFAULT_W = 16;
    localparam int unsigned STATE_W   = 2;
    localparam int unsigned CELL_W    = 16;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Controller-side sequencing around a multiply request.
    typedef enum logic [STATE_W-1:0] {
        CTL_IDLE      = 2'd0,
        CTL_MULT_1    = 2'd1,
        CTL_MULT_WAIT = 2'd2
    } ctl_state_t;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mul_add2w.sv
// 2W-bit accumulate adder, sum = acc + addend with the final carry discarded,
// assembled as a ripple of 16-bit adder cells.
module mul_add2w
    import seq_multiplier_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic [2*W-1:0] acc,
    input  logic [2*W-1:0] addend,
    output logic [2*W-1:0] sum
);

    localparam int unsigned SW  = 2 * W;
    localparam int unsigned NSL = (SW + CELL_W - 1) / CELL_W;
    localparam int unsigned PW  = NSL * CELL_W;
    localparam int unsigned CW1 = CELL_W + 1;

    logic [PW-1:0]  acc_p;
    logic [PW-1:0]  add_p;
    logic [PW-1:0]  sum_p;
    logic [NSL-1:0] carry;

    assign acc_p    = PW'(acc);
    assign add_p    = PW'(addend);
    assign carry[0] = 1'b0;

    // The top cell drops its carry-out, giving the modulo-2^(2W) sum.
    for (genvar i = 0; i < NSL; i++) begin : g_cell
        if (i == NSL - 1) begin : g_top
            assign sum_p[i*CELL_W +: CELL_W] = acc_p[i*CELL_W +: CELL_W]
                                             + add_p[i*CELL_W +: CELL_W]
                                             + CELL_W'(carry[i]);
        end else begin : g_mid
            assign {carry[i+1], sum_p[i*CELL_W +: CELL_W]} =
                CW1'(acc_p[i*CELL_W +: CELL_W])
              + CW1'(add_p[i*CELL_W +: CELL_W])
              + CW1'(carry[i]);
        end
    end

    assign sum = sum_p[SW-1:0];

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned W x W sequential shift-add multiplier: fixed W-cycle RUN phase,
// result held in DONE until the next accepted load.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product,
    output logic           ovf,
    output logic           busy,
    output logic           done
);

    localparam int unsigned PW    = 2 * W;
    localparam int unsigned CNT_W = cnt_width(W);

    mul_state_t       state;
    mul_state_t       state_nxt;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_sum;
    logic [W-1:0]     mplier;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last_iter;

    assign accept    = load && ((state == IDLE) || (state == DONE));
    assign last_iter = (cnt == CNT_W'(W - 1));

    mul_add2w #(
        .W (W)
    ) u_add (
        .acc    (acc),
        .addend (mcand),
        .sum    (acc_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Load is honoured only outside RUN; RUN always lasts exactly W cycles.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (load) state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = DONE;
            DONE:    if (load) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and status flags; busy/done track the registered state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= (state_nxt == DONE);
            if (accept) begin
                mcand  <= {{W{1'b0}}, a};
                mplier <= b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == RUN) begin
                if (mplier[0]) acc <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
            end
        end
    end

    assign product = acc;
    assign ovf     = |acc[PW-1:W];

endmodule
